delay_sched: RTL and testbench

- Controller for the 256-tap delay line; owns that line's 8-bit delay select.
- Accepts delay-change requests over a valid/ready config handshake and applies them in one of two modes:
  - ramp: ±1 tap per dwell period, with no phase jump;
  - jump: immediate change, with output blanking while the line settles.
- Sits between the register bank and the delay line, and also conditions the line's output stream.

---
 rtl/delay_sched_pkg.sv | 18 +
 rtl/delay_sched_stepper.sv | 59 +++++
 rtl/delay_sched.sv | 125 ++++++++++++
 tb/tb_delay_sched.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/delay_sched_pkg.sv
// Shared definitions for the delay-line scheduler and the delay line itself.
// Holds default widths, the blanking margin and the FSM state encoding.
package delay_sched_pkg;

    localparam int DEF_SEL_W   = 8;
    localparam int DEF_DWELL_W = 16;
    localparam int DEF_DATA_W  = 16;

    // Settling margin added to the new delay when blanking after a jump
    localparam int BLANK_EXTRA = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

endpackage

// File: rtl/delay_sched_stepper.sv
// Dwell timer and saturating +/-1 step toward the target for ramp transitions.
// The owner applies sel_next when step is high; at_target flags the final step.
module delay_sched_stepper
    import delay_sched_pkg::*;
#(
    parameter int SEL_W   = DEF_SEL_W,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [SEL_W-1:0]   target,
    input  logic [SEL_W-1:0]   sel,
    output logic               step,
    output logic [SEL_W-1:0]   sel_next,
    output logic               at_target
);

    localparam logic [SEL_W-1:0] SEL_MAX = {SEL_W{1'b1}};

    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_eff;

    // A zero dwell would stall the down-counter, so it means one clock per step
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            dwell_q <= DWELL_W'(1);
        end else if (start) begin
            cnt     <= dwell_eff;
            dwell_q <= dwell_eff;
        end else if (run) begin
            if (cnt == DWELL_W'(1)) begin
                cnt <= dwell_q;
            end else begin
                cnt <= cnt - DWELL_W'(1);
            end
        end
    end

    assign step = run && (cnt == DWELL_W'(1));

    always_comb begin
        sel_next = sel;
        if (sel < target) begin
            sel_next = (sel == SEL_MAX) ? sel : sel + SEL_W'(1);
        end else if (sel > target) begin
            sel_next = (sel == '0) ? sel : sel - SEL_W'(1);
        end
    end

    assign at_target = (sel_next == target);

endmodule

// File: rtl/delay_sched.sv
// Delay-line select controller: accepts delay changes and applies them as a
// phase-continuous ramp or as a jump with output blanking while the line settles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | settled; config ready; data passes through with 1 clk latency
// ST_RAMP  | stepping sel_o by one tap per dwell period toward the target
// ST_BLANK | sel_o jumped; data_o frozen and invalid until the line settles
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int SEL_W   = DEF_SEL_W,
    parameter int DWELL_W = DEF_DWELL_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic [SEL_W-1:0]         cfg_target_i,
    input  logic [DWELL_W-1:0]       cfg_dwell_i,
    input  logic                     cfg_ramp_i,
    output logic [SEL_W-1:0]         sel_o,
    input  logic signed [DATA_W-1:0] data_dly_i,
    output logic signed [DATA_W-1:0] data_o,
    output logic                     data_valid_o,
    output logic                     busy_o,
    output logic                     done_o
);

    state_t             state;
    logic [SEL_W-1:0]   target;
    logic [SEL_W:0]     blank_cnt;
    logic               accept;
    logic               ramp_start;
    logic               step;
    logic [SEL_W-1:0]   sel_next;
    logic               at_target;

    assign cfg_ready_o = (state == ST_IDLE);
    assign accept      = cfg_valid_i && cfg_ready_o;
    assign ramp_start  = accept && cfg_ramp_i && (cfg_target_i != sel_o);

    delay_sched_stepper #(
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) u_stepper (
        .clk       (clk),
        .reset     (reset),
        .start     (ramp_start),
        .run       (state == ST_RAMP),
        .dwell     (cfg_dwell_i),
        .target    (target),
        .sel       (sel_o),
        .step      (step),
        .sel_next  (sel_next),
        .at_target (at_target)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            target       <= '0;
            blank_cnt    <= '0;
            sel_o        <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    data_o       <= data_dly_i;
                    data_valid_o <= 1'b1;
                    if (accept) begin
                        target <= cfg_target_i;
                        if (cfg_target_i == sel_o) begin
                            done_o <= 1'b1;
                        end else if (cfg_ramp_i) begin
                            state  <= ST_RAMP;
                            busy_o <= 1'b1;
                        end else begin
                            sel_o        <= cfg_target_i;
                            blank_cnt    <= {1'b0, cfg_target_i} + (SEL_W+1)'(BLANK_EXTRA);
                            state        <= ST_BLANK;
                            busy_o       <= 1'b1;
                            data_valid_o <= 1'b0;
                        end
                    end
                end
                ST_RAMP: begin
                    data_o       <= data_dly_i;
                    data_valid_o <= 1'b1;
                    if (step) begin
                        sel_o <= sel_next;
                        if (at_target) begin
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end
                end
                ST_BLANK: begin
                    // Reload data on the final edge so valid rises with fresh data
                    if (blank_cnt <= (SEL_W+1)'(1)) begin
                        blank_cnt    <= '0;
                        state        <= ST_IDLE;
                        data_o       <= data_dly_i;
                        data_valid_o <= 1'b1;
                        busy_o       <= 1'b0;
                        done_o       <= 1'b1;
                    end else begin
                        blank_cnt <= blank_cnt - (SEL_W+1)'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_sched.sv
// Directed bench for delay_sched: reset, ramp up/down, jump blanking,
// busy rejection, null request and reset during blanking.
module tb_delay_sched;

    logic               clk;
    logic               reset;
    logic               cfg_valid_i;
    logic               cfg_ready_o;
    logic [7:0]         cfg_target_i;
    logic [15:0]        cfg_dwell_i;
    logic               cfg_ramp_i;
    logic [7:0]         sel_o;
    logic signed [15:0] data_dly_i;
    logic signed [15:0] data_o;
    logic               data_valid_o;
    logic               busy_o;
    logic               done_o;

    int n_cmp;
    int n_err;
    logic signed [15:0] sine [16];

    delay_sched dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_target_i (cfg_target_i),
        .cfg_dwell_i  (cfg_dwell_i),
        .cfg_ramp_i   (cfg_ramp_i),
        .sel_o        (sel_o),
        .data_dly_i   (data_dly_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0; cfg_valid_i = 1'b1; cfg_target_i = 8'd50;
        cfg_dwell_i = 16'd2; cfg_ramp_i = 1'b0; data_dly_i = 16'sh1234;
        repeat (4) @(negedge clk);
        n_cmp++; if (sel_o !== 8'd0) begin n_err++; $display("FAIL reset_sel got %0d want 0", sel_o); end
        n_cmp++; if (data_o !== 16'sd0) begin n_err++; $display("FAIL reset_data got %0d want 0", data_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy_o); end
        n_cmp++; if (cfg_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", cfg_ready_o); end
        n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", data_valid_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b want 0", done_o); end
        cfg_valid_i = 1'b0; reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (data_valid_o !== 1'b1) begin n_err++; $display("FAIL release_valid got %0b want 1", data_valid_o); end
        n_cmp++; if (sel_o !== 8'd0) begin n_err++; $display("FAIL release_sel got %0d want 0", sel_o); end
        n_cmp++; if (data_o !== 16'sh1234) begin n_err++; $display("FAIL release_data got %0d want %0d", data_o, 16'sh1234); end
    endtask

    task automatic test_ramp_up();
        logic signed [15:0] prev;
        cfg_valid_i = 1'b1; cfg_target_i = 8'd20; cfg_dwell_i = 16'd3; cfg_ramp_i = 1'b1;
        @(negedge clk);
        cfg_valid_i = 1'b0;
        n_cmp++; if (busy_o !== 1'b1 || cfg_ready_o !== 1'b0) begin n_err++; $display("FAIL rampup_start busy/ready got %0b/%0b want 1/0", busy_o, cfg_ready_o); end
        for (int k = 1; k <= 61; k++) begin
            prev = 16'(k * 7 - 100);
            data_dly_i = prev;
            @(negedge clk);
            n_cmp++; if (sel_o !== 8'((k > 60 ? 60 : k) / 3)) begin n_err++; $display("FAIL rampup_sel k=%0d got %0d want %0d", k, sel_o, (k > 60 ? 60 : k) / 3); end
            n_cmp++; if (done_o !== (k == 60)) begin n_err++; $display("FAIL rampup_done k=%0d got %0b want %0b", k, done_o, k == 60); end
            n_cmp++; if (data_valid_o !== 1'b1) begin n_err++; $display("FAIL rampup_valid k=%0d got %0b want 1", k, data_valid_o); end
            n_cmp++; if (data_o !== prev) begin n_err++; $display("FAIL rampup_data k=%0d got %0d want %0d", k, data_o, prev); end
            n_cmp++; if (busy_o !== (k < 60)) begin n_err++; $display("FAIL rampup_busy k=%0d got %0b want %0b", k, busy_o, k < 60); end
        end
    endtask

    task automatic test_ramp_down_d0();
        cfg_valid_i = 1'b1; cfg_target_i = 8'd17; cfg_dwell_i = 16'd0; cfg_ramp_i = 1'b1;
        @(negedge clk);
        cfg_valid_i = 1'b0;
        n_cmp++; if (sel_o !== 8'd20 || busy_o !== 1'b1) begin n_err++; $display("FAIL rampdn_start sel/busy got %0d/%0b want 20/1", sel_o, busy_o); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_cmp++; if (sel_o !== 8'(20 - (k > 3 ? 3 : k))) begin n_err++; $display("FAIL rampdn_sel k=%0d got %0d want %0d", k, sel_o, 20 - (k > 3 ? 3 : k)); end
            n_cmp++; if (done_o !== (k == 3)) begin n_err++; $display("FAIL rampdn_done k=%0d got %0b want %0b", k, done_o, k == 3); end
        end
    endtask

    task automatic test_jump();
        logic signed [15:0] frozen;
        logic signed [15:0] drv;
        frozen = sine[4];
        data_dly_i = frozen;
        cfg_valid_i = 1'b1; cfg_target_i = 8'd255; cfg_ramp_i = 1'b0;
        @(negedge clk);
        cfg_valid_i = 1'b0;
        n_cmp++; if (sel_o !== 8'd255) begin n_err++; $display("FAIL jump_sel got %0d want 255", sel_o); end
        n_cmp++; if (data_valid_o !== 1'b0 || busy_o !== 1'b1) begin n_err++; $display("FAIL jump_start valid/busy got %0b/%0b want 0/1", data_valid_o, busy_o); end
        n_cmp++; if (data_o !== frozen) begin n_err++; $display("FAIL jump_last_data got %0d want %0d", data_o, frozen); end
        for (int k = 1; k <= 259; k++) begin
            drv = sine[(k + 4) & 15];
            data_dly_i = drv;
            @(negedge clk);
            if (k < 257) begin
                n_cmp++; if (data_valid_o !== 1'b0 || data_o !== frozen || busy_o !== 1'b1 || done_o !== 1'b0) begin
                    n_err++; $display("FAIL jump_blank k=%0d valid=%0b data=%0d busy=%0b done=%0b want 0/%0d/1/0", k, data_valid_o, data_o, busy_o, done_o, frozen);
                end
            end else begin
                n_cmp++; if (data_valid_o !== 1'b1 || data_o !== drv || busy_o !== 1'b0) begin
                    n_err++; $display("FAIL jump_settled k=%0d valid=%0b data=%0d busy=%0b want 1/%0d/0", k, data_valid_o, data_o, busy_o, drv);
                end
                n_cmp++; if (done_o !== (k == 257)) begin n_err++; $display("FAIL jump_done k=%0d got %0b want %0b", k, done_o, k == 257); end
            end
        end
        n_cmp++; if (sel_o !== 8'd255) begin n_err++; $display("FAIL jump_sel_end got %0d want 255", sel_o); end
    endtask

    task automatic test_busy_null();
        cfg_valid_i = 1'b1; cfg_target_i = 8'd253; cfg_dwell_i = 16'd4; cfg_ramp_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL busy_start got %0b want 1", busy_o); end
        cfg_target_i = 8'd0; cfg_ramp_i = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 4) cfg_valid_i = 1'b0;
            if (k < 4) begin
                n_cmp++; if (cfg_ready_o !== 1'b0) begin n_err++; $display("FAIL busy_ready k=%0d got %0b want 0", k, cfg_ready_o); end
            end
            @(negedge clk);
            n_cmp++; if (sel_o !== 8'(255 - (k > 8 ? 8 : k) / 4)) begin n_err++; $display("FAIL busy_sel k=%0d got %0d want %0d", k, sel_o, 255 - (k > 8 ? 8 : k) / 4); end
            n_cmp++; if (done_o !== (k == 8)) begin n_err++; $display("FAIL busy_done k=%0d got %0b want %0b", k, done_o, k == 8); end
        end
        cfg_valid_i = 1'b1; cfg_target_i = 8'd253; cfg_ramp_i = 1'b1;
        @(negedge clk);
        cfg_valid_i = 1'b0;
        n_cmp++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL null_pulse done/busy got %0b/%0b want 1/0", done_o, busy_o); end
        n_cmp++; if (sel_o !== 8'd253 || cfg_ready_o !== 1'b1) begin n_err++; $display("FAIL null_state sel/ready got %0d/%0b want 253/1", sel_o, cfg_ready_o); end
        @(negedge clk);
        n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL null_after done/busy got %0b/%0b want 0/0", done_o, busy_o); end
    endtask

    task automatic test_reset_mid_blank();
        cfg_valid_i = 1'b1; cfg_target_i = 8'd200; cfg_ramp_i = 1'b0;
        @(negedge clk);
        cfg_valid_i = 1'b0;
        repeat (102) @(negedge clk);
        n_cmp++; if (busy_o !== 1'b1 || sel_o !== 8'd200) begin n_err++; $display("FAIL midblank_pre busy/sel got %0b/%0d want 1/200", busy_o, sel_o); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (sel_o !== 8'd0) begin n_err++; $display("FAIL midblank_sel got %0d want 0", sel_o); end
        n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b0 || cfg_ready_o !== 1'b1) begin n_err++; $display("FAIL midblank_state done/busy/ready got %0b/%0b/%0b want 0/0/1", done_o, busy_o, cfg_ready_o); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (done_o !== 1'b0 || data_valid_o !== 1'b1 || sel_o !== 8'd0) begin n_err++; $display("FAIL midblank_after done/valid/sel got %0b/%0b/%0d want 0/1/0", done_o, data_valid_o, sel_o); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        sine = '{16'sd0, 16'sd11481, 16'sd21213, 16'sd27716, 16'sd30000, 16'sd27716, 16'sd21213, 16'sd11481,
                 16'sd0, -16'sd11481, -16'sd21213, -16'sd27716, -16'sd30000, -16'sd27716, -16'sd21213, -16'sd11481};
        reset = 1'b0; cfg_valid_i = 1'b0; cfg_target_i = '0; cfg_dwell_i = '0;
        cfg_ramp_i = 1'b0; data_dly_i = '0;
        @(negedge clk);
        test_reset();
        test_ramp_up();
        test_ramp_down_d0();
        test_jump();
        test_busy_null();
        test_reset_mid_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
